onehot_grant_decoder: RTL and testbench
=======================================

# onehot_grant_decoder

Sequential 3-to-8 decoder: the decode-side counterpart of the 8-input priority encoder. It accepts an encoded 3-bit index with a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles. It then releases the line and signals completion. It sits downstream of the priority encoder and turns the winning index back into a timed, one-hot grant for the selected requester.

## Interface
- `HOLD_CYCLES`, default 4: number of cycles the one-hot grant is held. Legal range is 1..255.
- `clk` input 1: system clock. All logic updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Y` input 3: encoded index to decode. `Y` = 0..7 selects `D[Y]`.
- `V` input 1: request valid. Distinguishes a real index 0 from "no input active".
- `ready` output 1: block can accept a request this cycle.
- `D` output 8: one-hot grant. All zeros when idle.
- `busy` output 1: a grant is in progress. Equals `|D`, registered.
- `done` output 1: single-cycle pulse when a grant ends normally.

## Operation
- States are IDLE, DRIVE and, only with the macro, GAP. The encoding is free.
- **IDLE:** `ready` = 1, `D` = 0, `busy` = 0.
  - When `V` && `ready` at an edge, the block captures `Y`, sets `D` = 8'b1 << `Y`, loads `cnt` = HOLD_CYCLES-1 and enters DRIVE.
- **DRIVE:** `ready` = 0, `busy` = 1 and `D` holds the captured one-hot value.
  - While `cnt` != 0, `cnt` decrements by 1 each cycle.
  - When `cnt` == 0, the next edge clears `D`, pulses `done` = 1 for one cycle and moves to IDLE, or to GAP when configured.
- `cnt` width is the minimum needed for HOLD_CYCLES-1. It never wraps, because the load happens only on entry to DRIVE.
- `Y` and `V` are ignored while `ready` = 0. A request held across DRIVE is accepted when `ready` returns; it is not lost.
- `D` always has at most one bit set, with no glitch between grants.
- **Reset:**
  - Effect: forces IDLE, `D` = 0, `busy` = 0, `done` = 0, `ready` = 1 and `cnt` = 0 on the next edge.
  - Reset mid-DRIVE: aborts the grant with no `done` pulse.
  - `rst` and `V` both high on the same edge: `rst` wins and the request is dropped.

## Timing
- Reset values: `D` = 8'h00, `busy` = 0, `done` = 0, `ready` = 1.
- All outputs are registered, and `ready` is a function of state only.
- Request accepted at edge k:
  - `D` is valid from edge k through edge k+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
  - `D` = 0 and `done` = 1 after edge k+HOLD_CYCLES.
- Without GAP, `ready` = 1 in the same cycle as `done`. A request presented then is accepted at edge k+HOLD_CYCLES+1.
  - The minimum low time of `D` between back-to-back grants is 1 cycle.
- Sustained throughput is one grant per HOLD_CYCLES+1 cycles, or HOLD_CYCLES+2 with GAP.
- HOLD_CYCLES = 1: `D` is high for a single cycle. DRIVE exits on the first edge after entry.

## Configuration
- Macro: `ONEHOT_GRANT_DECODER_GAP_EN`.
- **Defined:** the exit from DRIVE goes to GAP for one cycle, then to IDLE.
  - In GAP, `D` = 0, `busy` = 0, `ready` = 0, and `done` pulses in GAP.
  - `ready` returns one cycle after `done`, giving a minimum of 2 cycles of all-zero `D` between grants.
- **Undefined:** the GAP state and its logic are absent, and DRIVE exits directly to IDLE as described above.

## Test plan
- **Reset defaults:** assert `rst` for 2 cycles with `V` = 1, `Y` = 5. After release, expect `D` = 8'h00, `ready` = 1, `busy` = 0, `done` = 0, and no grant during reset.
- **Single grant:** HOLD_CYCLES = 4, `Y` = 3, `V` = 1 for one cycle. Expect `D` = 8'h08 for exactly 4 cycles, then `D` = 0 with `done` = 1 for one cycle and `ready` = 1.
- **Full decode sweep:** apply `Y` = 0..7 back-to-back with `V` held high. Expect `D` = 8'h01, 8'h02 ... 8'h80 in order, each held 4 cycles, with one zero cycle and one `done` between grants (two zero cycles with GAP).
- **Index 0 vs no request:** `Y` = 0 with `V` = 0 for 10 cycles gives `D` = 0 throughout. `Y` = 0 with `V` = 1 gives `D` = 8'h01.
- **Reset mid-operation:** assert `rst` in cycle 2 of a `Y` = 6 grant. Expect `D` = 0 on the next edge, no `done`, and `ready` = 1.
- **Minimum hold:** HOLD_CYCLES = 1, `Y` = 7. Expect `D` = 8'h80 for exactly one cycle and `done` in the following cycle.

Source files
------------

// File: rtl/onehot_grant_decoder_if.sv
// onehot_grant_decoder_if: index request in, timed one-hot grant and status out
interface onehot_grant_decoder_if;
    logic [2:0] Y;
    logic       V;
    logic       ready;
    logic [7:0] D;
    logic       busy;
    logic       done;
    modport master (output Y, V, input ready, D, busy, done);
    modport slave (input Y, V, output ready, D, busy, done);
endinterface

// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder: 3-to-8 decoder holding a one-hot grant for HOLD_CYCLES cycles (optional GAP state via ONEHOT_GRANT_DECODER_GAP_EN)
module onehot_grant_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input logic                    clk,
    input logic                    rst,
    onehot_grant_decoder_if.slave  bus
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef ONEHOT_GRANT_DECODER_GAP_EN
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
`else
    typedef enum logic {IDLE, DRIVE} state_t;
`endif
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      d_q, d_d;
    logic            busy_q, done_q, done_d;
    // next state: capture on request in IDLE, count down in DRIVE, release with a done pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.V) begin
                state_d = DRIVE;
                d_d     = 8'b1 << bus.Y;
                cnt_d   = CW'(HOLD_CYCLES - 1);
            end
            DRIVE: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                d_d    = 8'h00;
                done_d = 1'b1;
`ifdef ONEHOT_GRANT_DECODER_GAP_EN
                state_d = GAP;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers; reset aborts any grant without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            busy_q  <= |d_d;
            done_q  <= done_d;
        end
    end
    assign bus.D     = d_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ready = (state_q == IDLE);
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb_onehot_grant_decoder: drives HOLD_CYCLES=4 and HOLD_CYCLES=1 instances with shared stimulus, timing model plus grant scoreboard
module tb_onehot_grant_decoder;
`ifdef ONEHOT_GRANT_DECODER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    typedef struct {logic [7:0] d; int len; bit done;} grant_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v = 1'b0;
    logic [2:0] y = 3'd0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    function automatic void chk(input int inst, input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL inst%0d %s got %0h expected %0h", inst, name, act, exp);
        end
    endfunction
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int H = (g == 0) ? 4 : 1;
        onehot_grant_decoder_if bus ();
        assign bus.V = v;
        assign bus.Y = y;
        onehot_grant_decoder #(.HOLD_CYCLES(H)) dut (.clk(clk), .rst(rst), .bus(bus));
        grant_t     q[$];
        int         e = 0;
        int         k = -100;
        int         free_at = 0;
        bit         live = 0;
        bit         armed = 0;
        logic [7:0] cur = 8'h00;
        logic [7:0] exp_d = 8'h00;
        bit         exp_done = 0;
        bit         exp_ready = 1;
        logic [7:0] prev_d = 8'h00;
        int         run = 0;
        // reference: edge-indexed timeline of accepted grants
        always @(posedge clk) begin
            if (rst) begin
                if (live && e <= k + H) begin
                    q[q.size() - 1].len = e - k;
                    q[q.size() - 1].done = 1'b0;
                end
                live = 0;
                armed = 1;
                free_at = e + 1;
            end else if (v && e >= free_at) begin
                k = e;
                cur = 8'h01 << y;
                live = 1;
                free_at = e + H + 1 + GAP;
                q.push_back('{cur, H, 1'b1});
            end
            exp_d = (live && e < k + H) ? cur : 8'h00;
            exp_done = live && (e == k + H);
            exp_ready = (e + 1 >= free_at);
            e++;
        end
        // monitor: per-cycle outputs, and whole-grant scoreboard when a grant ends
        always @(negedge clk) begin
            if (armed) begin
                chk(g, bus.D == exp_d, "D", 32'(bus.D), 32'(exp_d));
                chk(g, bus.done == exp_done, "done", 32'(bus.done), 32'(exp_done));
                chk(g, bus.ready == exp_ready, "ready", 32'(bus.ready), 32'(exp_ready));
                chk(g, bus.busy == (exp_d != 0), "busy", 32'(bus.busy), 32'(exp_d != 0));
                if (prev_d != 8'h00 && bus.D != prev_d) begin
                    if (q.size() == 0) begin
                        chk(g, 1'b0, "unexpected_grant", 32'(prev_d), 32'h0);
                    end else begin
                        grant_t r;
                        r = q.pop_front();
                        chk(g, prev_d == r.d, "grant_value", 32'(prev_d), 32'(r.d));
                        chk(g, run == r.len, "grant_length", 32'(run), 32'(r.len));
                        chk(g, bus.done == r.done, "grant_done", 32'(bus.done), 32'(r.done));
                    end
                end
                run = (bus.D == 8'h00) ? 0 : (bus.D == prev_d) ? run + 1 : 1;
                prev_d = bus.D;
            end
        end
    end
    initial begin
        rst = 1'b1; v = 1'b1; y = 3'd5;
        repeat (2) @(negedge clk);
        rst = 1'b0; v = 1'b0;
        repeat (3) @(negedge clk);
        y = 3'd3; v = 1'b1;
        @(negedge clk);
        v = 1'b0;
        repeat (8) @(negedge clk);
        v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y = 3'(i);
            repeat (5 + GAP) @(negedge clk);
        end
        v = 1'b0; y = 3'd0;
        repeat (10) @(negedge clk);
        v = 1'b1;
        @(negedge clk);
        v = 1'b0;
        repeat (6) @(negedge clk);
        y = 3'd6; v = 1'b1;
        @(negedge clk);
        v = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) != 0);
            y = 3'($urandom);
            rst = ($urandom_range(0, 60) == 0);
            @(negedge clk);
        end
        rst = 1'b0; v = 1'b0;
        repeat (20) @(negedge clk);
        chk(0, u[0].q.size() == 0, "pending_grants", 32'(u[0].q.size()), 32'h0);
        chk(1, u[1].q.size() == 0, "pending_grants", 32'(u[1].q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
